clk_div_multi: RTL and testbench



---
 rtl/clk_div_multi.sv | 120 ++++++++++++
 tb/tb_clk_div_multi.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel counts system clocks up to a runtime-loadable half-period D
// and, at every wrap, emits a one-cycle tick and either toggles its divided
// clock (clock mode) or pulses it (pulse mode). Divisor and mode updates to a
// running channel are held in a shadow register and applied at the next wrap,
// so the output never sees a truncated or stretched half-period.
module clk_div_multi #(
   parameter int                NUM_CH      = 4,
   parameter int                CNT_W       = 16,
   parameter logic [CNT_W-1:0]  DEFAULT_DIV = CNT_W'(21),
   localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [CNT_W-1:0]  wr_div,
   input  logic              wr_mode,
   input  logic              sync,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pend
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] div_act;
      logic [CNT_W-1:0] div_sh;
      logic             mode_act;
      logic             mode_sh;
      logic             pend_q;
      logic             clk_q;
      logic             tick_q;

      logic [CNT_W-1:0] d_eff;
      logic             hit;
      logic             restart;
      logic             wrap;
      logic             do_apply;
      logic [CNT_W-1:0] nxt_div;
      logic             nxt_mode;

      // Decode wrap/restart and pick which divisor/mode (fresh write or shadow) gets applied.
      // Out-of-range channel numbers match no channel, so such writes simply vanish.
      always_comb begin
         d_eff    = (div_act == '0) ? ONE : div_act;
         hit      = wr_en && (int'(wr_ch) == i);
         restart  = sync || !en[i];
         wrap     = !restart && (cnt >= d_eff - ONE);
         do_apply = 1'b0;
         nxt_div  = div_sh;
         nxt_mode = mode_sh;
         if (hit) begin
            nxt_div  = wr_div;
            nxt_mode = wr_mode;
            do_apply = restart || wrap;
         end else if (pend_q) begin
            do_apply = restart || wrap;
         end
      end

      // Channel state: counter, active/shadow divisor, registered clock and tick outputs.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt      <= '0;
            div_act  <= DEFAULT_DIV;
            div_sh   <= '0;
            mode_act <= 1'b0;
            mode_sh  <= 1'b0;
            pend_q   <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
         end else begin
            // A write landing on a wrap or restart goes straight to the active
            // registers; otherwise a running channel parks it in the shadow.
            if (do_apply) begin
               div_act  <= nxt_div;
               mode_act <= nxt_mode;
               pend_q   <= 1'b0;
            end else if (hit) begin
               div_sh  <= wr_div;
               mode_sh <= wr_mode;
               pend_q  <= 1'b1;
            end

            if (restart) begin
               cnt    <= '0;
               clk_q  <= 1'b0;
               tick_q <= 1'b0;
            end else if (wrap) begin
               // The wrap itself always uses the old divisor; a mode change
               // starts the new mode from a low output.
               cnt    <= '0;
               tick_q <= 1'b1;
               if (do_apply && (nxt_mode != mode_act)) begin
                  clk_q <= 1'b0;
               end else if (mode_act) begin
                  clk_q <= 1'b1;
               end else begin
                  clk_q <= ~clk_q;
               end
            end else begin
               cnt    <= cnt + ONE;
               tick_q <= 1'b0;
               if (mode_act) begin
                  clk_q <= 1'b0;
               end
            end
         end
      end

      assign clk_out[i] = clk_q;
      assign tick[i]    = tick_q;
      assign pend[i]    = pend_q;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: reference model feeding a scoreboard queue,
// a table of hand-derived vectors, and hand-written corner sequences.
module tb_clk_div_multi;

   logic        clk;
   logic        rst;
   logic [3:0]  en;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [15:0] wr_div;
   logic        wr_mode;
   logic        sync;
   logic [3:0]  clk_out;
   logic [3:0]  tick;
   logic [3:0]  pend;

   // Three-channel instance: a 2-bit channel select can address a missing channel.
   logic [2:0]  en3;
   logic        wr3_en;
   logic [1:0]  wr3_ch;
   logic [15:0] wr3_div;
   logic [2:0]  clk_out3;
   logic [2:0]  tick3;
   logic [2:0]  pend3;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0] c;
      logic [3:0] t;
      logic [3:0] p;
   } exp_t;

   typedef struct {
      logic [3:0]  e;
      logic        we;
      logic [1:0]  wc;
      logic [15:0] wd;
      logic        wm;
      logic        sy;
      logic [3:0]  c;
      logic [3:0]  t;
      logic [3:0]  p;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[18];

   int m_cnt[4], m_div[4], m_mode[4], m_sdiv[4], m_smode[4], m_pend[4], m_clk[4], m_tick[4];

   clk_div_multi #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(16'd21)) u_dut (
      .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
      .wr_mode(wr_mode), .sync(sync), .clk_out(clk_out), .tick(tick), .pend(pend)
   );

   clk_div_multi #(.NUM_CH(3), .CNT_W(16), .DEFAULT_DIV(16'd2)) u_dut3 (
      .clk(clk), .rst(rst), .en(en3), .wr_en(wr3_en), .wr_ch(wr3_ch), .wr_div(wr3_div),
      .wr_mode(1'b0), .sync(1'b0), .clk_out(clk_out3), .tick(tick3), .pend(pend3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < 4; ch++) begin
         m_cnt[ch] = 0; m_div[ch] = 21; m_mode[ch] = 0; m_sdiv[ch] = 0;
         m_smode[ch] = 0; m_pend[ch] = 0; m_clk[ch] = 0; m_tick[ch] = 0;
      end
   endtask

   // Next-cycle behaviour of every channel given this cycle's inputs.
   task automatic model_step(input logic [3:0] e, input logic we, input int wc, input int wd,
                             input int wm, input logic sy, output exp_t r);
      for (int ch = 0; ch < 4; ch++) begin
         int  d, nd, nm;
         bit  hit, restart, wrap, app;
         d       = (m_div[ch] == 0) ? 1 : m_div[ch];
         hit     = we && (wc == ch);
         restart = sy || !e[ch];
         wrap    = !restart && (m_cnt[ch] == d - 1);
         app = 0; nd = 0; nm = 0;
         if (hit && (restart || wrap)) begin
            app = 1; nd = wd; nm = wm;
         end else if (hit) begin
            m_sdiv[ch] = wd; m_smode[ch] = wm; m_pend[ch] = 1;
         end else if (m_pend[ch] != 0 && (restart || wrap)) begin
            app = 1; nd = m_sdiv[ch]; nm = m_smode[ch];
         end
         if (restart) begin
            m_cnt[ch] = 0; m_clk[ch] = 0; m_tick[ch] = 0;
         end else if (wrap) begin
            m_cnt[ch] = 0; m_tick[ch] = 1;
            if (app && nm != m_mode[ch]) m_clk[ch] = 0;
            else if (m_mode[ch] != 0)    m_clk[ch] = 1;
            else                         m_clk[ch] = 1 - m_clk[ch];
         end else begin
            m_cnt[ch]++; m_tick[ch] = 0;
            if (m_mode[ch] != 0) m_clk[ch] = 0;
         end
         if (app) begin
            m_div[ch] = nd; m_mode[ch] = nm; m_pend[ch] = 0;
         end
         r.c[ch] = m_clk[ch][0];
         r.t[ch] = m_tick[ch][0];
         r.p[ch] = m_pend[ch][0];
      end
   endtask

   // Drive one cycle, queue its expectation, and check it after the edge.
   task automatic apply_chk(input logic [3:0] e, input logic we, input logic [1:0] wc,
                            input logic [15:0] wd, input logic wm, input logic sy,
                            input exp_t x, input string nm);
      exp_t w;
      en = e; wr_en = we; wr_ch = wc; wr_div = wd; wr_mode = wm; sync = sy;
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      w = sb_q.pop_front();
      tests++;
      if (clk_out !== w.c || tick !== w.t || pend !== w.p) begin
         fails++;
         $display("FAIL %s #%0d: got clk_out=%b tick=%b pend=%b, want clk_out=%b tick=%b pend=%b",
                  nm, tests, clk_out, tick, pend, w.c, w.t, w.p);
      end
   endtask

   task automatic step(input logic [3:0] e, input logic we, input logic [1:0] wc,
                       input logic [15:0] wd, input logic wm, input logic sy);
      exp_t r;
      model_step(e, we, int'(wc), int'(wd), int'(wm), sy, r);
      apply_chk(e, we, wc, wd, wm, sy, r, "model");
   endtask

   task automatic run(input int n, input logic [3:0] e);
      for (int k = 0; k < n; k++) step(e, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input logic [3:0] e);
      en = e; wr_en = 0; wr_ch = 0; wr_div = 0; wr_mode = 0; sync = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset clk_out", 32'(clk_out), 32'h0);
      chk("reset tick", 32'(tick), 32'h0);
      chk("reset pend", 32'(pend), 32'h0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int first, nt0, nt1, f0, f1, f2;
      en3 = 3'b111; wr3_en = 0; wr3_ch = 0; wr3_div = 0;

      // Default divisor after reset: toggles at edges 21, 42, 63.
      do_reset(4'hF);
      first = 0; nt0 = 0;
      for (int k = 1; k <= 63; k++) begin
         run(1, 4'hF);
         if (tick[0] && first == 0) first = k;
         if (tick[0]) nt0++;
      end
      chk("first tick edge", 32'(first), 32'd21);
      chk("ticks in 63 edges", 32'(nt0), 32'd3);
      chk("clk_out after edge 63", 32'(clk_out), 32'hF);

      // Shadowed retune of ch1 at cnt=10, applied at its wrap.
      run(10, 4'hF);
      step(4'hF, 1'b1, 2'd1, 16'd5, 1'b0, 1'b0);
      chk("pend after shadow write", 32'(pend), 32'h2);
      run(9, 4'hF);
      chk("pend held until wrap", 32'(pend[1]), 32'h1);
      run(1, 4'hF);
      chk("pend cleared at wrap", 32'(pend), 32'h0);
      chk("tick at apply wrap", 32'(tick), 32'hF);
      nt0 = 0; nt1 = 0;
      for (int k = 0; k < 20; k++) begin
         run(1, 4'hF);
         if (tick[0]) nt0++;
         if (tick[1]) nt1++;
      end
      chk("ch1 ticks at D=5", 32'(nt1), 32'd4);
      chk("ch0 unaffected", 32'(nt0), 32'd0);

      // Retune to 4/6/8, let them drift out of phase, then sync.
      step(4'hF, 1'b1, 2'd0, 16'd4, 1'b0, 1'b0);
      step(4'hF, 1'b1, 2'd1, 16'd6, 1'b0, 1'b0);
      step(4'hF, 1'b1, 2'd2, 16'd8, 1'b0, 1'b0);
      run(30 + int'($urandom_range(0, 7)), 4'hF);
      step(4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
      chk("sync clears clk_out", 32'(clk_out), 32'h0);
      f0 = 0; f1 = 0; f2 = 0;
      for (int k = 1; k <= 8; k++) begin
         run(1, 4'hF);
         if (tick[0] && f0 == 0) f0 = k;
         if (tick[1] && f1 == 0) f1 = k;
         if (tick[2] && f2 == 0) f2 = k;
         if (k == 8) chk("ch0/ch2 coincide at 8", 32'({tick[2], tick[0]}), 32'h3);
      end
      chk("ch0 first tick after sync", 32'(f0), 32'd4);
      chk("ch1 first tick after sync", 32'(f1), 32'd6);
      chk("ch2 first tick after sync", 32'(f2), 32'd8);

      // Reset in the middle of a period with a pending write on ch3.
      step(4'hF, 1'b1, 2'd3, 16'd9, 1'b1, 1'b0);
      chk("ch3 pending", 32'(pend[3]), 32'h1);
      run(3, 4'hF);
      rst = 1'b1;
      #1;
      chk("async rst clk_out", 32'(clk_out), 32'h0);
      chk("async rst tick", 32'(tick), 32'h0);
      chk("async rst pend", 32'(pend), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      first = 0;
      for (int k = 1; k <= 42; k++) begin
         run(1, 4'hF);
         if (tick[3] && first == 0) first = k;
         if (k == 21) chk("ch3 clock mode after rst", 32'(clk_out[3]), 32'h1);
      end
      chk("ch3 first tick after rst", 32'(first), 32'd21);

      // Hand-derived vectors: disabled loads, D=1, pulse mode, same-cycle wrap writes, sync+write.
      //           en       we  wc     wd      wm  sy  clk_out  tick     pend
      tbl[0]  = '{4'b0000, 1, 2'd2, 16'd3, 1, 0, 4'b0000, 4'b0000, 4'b0000};
      tbl[1]  = '{4'b0000, 1, 2'd0, 16'd0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
      tbl[2]  = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0001, 4'b0001, 4'b0000};
      tbl[3]  = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0000, 4'b0001, 4'b0000};
      tbl[4]  = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0101, 4'b0101, 4'b0000};
      tbl[5]  = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0000, 4'b0001, 4'b0000};
      tbl[6]  = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0001, 4'b0001, 4'b0000};
      tbl[7]  = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0100, 4'b0101, 4'b0000};
      tbl[8]  = '{4'b0101, 1, 2'd0, 16'd4, 0, 0, 4'b0001, 4'b0001, 4'b0000};
      tbl[9]  = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0001, 4'b0000, 4'b0000};
      tbl[10] = '{4'b0101, 1, 2'd2, 16'd5, 0, 0, 4'b0001, 4'b0100, 4'b0000};
      tbl[11] = '{4'b0101, 1, 2'd0, 16'd2, 1, 0, 4'b0001, 4'b0000, 4'b0001};
      tbl[12] = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0000, 4'b0001, 4'b0000};
      tbl[13] = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
      tbl[14] = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0001, 4'b0001, 4'b0000};
      tbl[15] = '{4'b0101, 0, 2'd0, 16'd0, 0, 0, 4'b0100, 4'b0100, 4'b0000};
      tbl[16] = '{4'b0101, 1, 2'd2, 16'd3, 0, 1, 4'b0000, 4'b0000, 4'b0000};
      tbl[17] = '{4'b0000, 0, 2'd0, 16'd0, 0, 0, 4'b0000, 4'b0000, 4'b0000};
      do_reset(4'h0);
      for (int i = 0; i < 18; i++) begin
         exp_t x;
         x.c = tbl[i].c; x.t = tbl[i].t; x.p = tbl[i].p;
         apply_chk(tbl[i].e, tbl[i].we, tbl[i].wc, tbl[i].wd, tbl[i].wm, tbl[i].sy, x, "vector");
      end

      // Write to a channel that does not exist on the three-channel instance.
      wr3_en = 1'b1; wr3_ch = 2'd3; wr3_div = 16'd7;
      @(posedge clk);
      #1;
      wr3_en = 1'b0;
      chk("out-of-range write pend", 32'(pend3), 32'h0);
      nt0 = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (tick3 == 3'b111) nt0++;
      end
      chk("out-of-range write keeps D=2", 32'(nt0), 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
